cu_pipe: RTL and testbench
==========================

# cu_pipe

Pipelined control unit for the 5-stage RV32I core. Decodes the instruction in Decode and delivers immediate select and illegal flag there. Carries the control bundle through its own Execute, Memory and Writeback registers. Resolves branches and jumps in Execute, with the full RV32I branch set and a widened ALU control. Sits beside the datapath pipeline registers, receives flushE from the hazard unit, and flushes its own Execute bubble on a taken control transfer.

## Interface
- ALUCTRL_W, 4, ALU control width; 4 is the minimum, because encodings reach 1010.
- IMMSRC_W, 3, immediate-select width; I, S, B, J, U formats.
- clk  in  1  core clock; all registers update on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- opD  in  7  opcode in Decode.
- funct3D  in  3  funct3 in Decode.
- funct7_5D  in  1  instruction bit 30 in Decode.
- flushE  in  1  hazard unit: load a bubble into the Execute register.
- zeroE / ltE / ltuE  in  1 each  ALU flags: equal, signed less-than, unsigned less-than.
- immsrcD  out  IMMSRC_W  immediate format: 000 I, 001 S, 010 B, 011 J, 100 U.
- illegalD  out  1  Decode opcode or funct3 is not valid RV32I.
- ALUsrcAE  out  1  ALU operand A source: 0 = rs1, 1 = PC (auipc).
- ALUsrcE  out  1  ALU operand B source: 0 = rs2, 1 = immediate.
- ALUctrlE  out  ALUCTRL_W  ALU operation.
- jumpE / jalrE / branchE  out  1 each  control-transfer class of the instruction in Execute.
- pcsrcE  out  1  control transfer taken; combinational from the Execute register and the ALU flags.
- memwrM  out  1  data-memory write strobe.
- regwrM / regwrW  out  1 each  register-file write enable in Memory / Writeback.
- resultsrcM / resultsrcW  out  2 each  result select: 00 ALU, 01 memory, 10 PC+4.
- trapW  out  1  sticky illegal-instruction trap; present only with the configuration macro below.

## Operation
- Decode is combinational. Control by opcode:
  - R (0110011): ALUop 10.
  - I-ALU (0010011): ALUop 10, immediate.
  - Load (0000011): ALUop 00, resultsrc 01.
  - Store (0100011): ALUop 00, memwr.
  - Branch (1100011): branch asserted.
  - jal (1101111): jump, resultsrc 10.
  - jalr (1100111): jump, jalr, ALU add, resultsrc 10.
  - lui (0110111): ALUop 11.
  - auipc (0010111): ALUsrcA = PC, ALU add.
- ALU control encodings: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt, 0110 sltu, 0111 sll, 1000 srl, 1001 sra, 1010 passB.
- ALU control selection:
  - ALUop 00: add.
  - ALUop 11: passB.
  - ALUop 10: select by funct3. sub only when opD[5]=1, funct7_5D=1 and funct3D=000. Shifts with funct3 101 choose sra when funct7_5D=1, for both R and I forms.
  - Branches: sub.
- Branch condition by funct3, evaluated in Execute:
  - 000: zeroE.
  - 001: !zeroE.
  - 100: ltE.
  - 101: !ltE.
  - 110: ltuE.
  - 111: !ltuE.
  - 010 / 011: illegal.
- pcsrcE = jumpE | (branchE & condition).
- Execute register update: loads a bubble (all control zero) when flushE=1 or pcsrcE=1; otherwise loads the Decode control.
- Memory and Writeback registers: never stall; shift every cycle.
- Unknown opcodes decode to an all-zero bundle.

## Timing
- Reset: every registered output and trapW is 0, so the pipeline holds bubbles.
- Latency: an instruction decoded in cycle N shows its control in E at N+1, in M at N+2 and in W at N+3.
- pcsrcE: zero-cycle, combinational from the Execute register and the flags. The following cycle's Execute register is always a bubble.
- flushE and pcsrcE together: a single bubble, with no extra effect.
- Reset asserted mid-stream: all stages clear immediately and asynchronously.

## Configuration
- CU_ILLEGAL_TRAP_EN defined:
  - An illegal instruction is forced to a bubble in Execute.
  - Its trap bit travels to W, and trapW sets and stays 1 until reset.
- CU_ILLEGAL_TRAP_EN undefined:
  - trapW is tied 0.
  - illegalD remains informational only.
  - Illegal funct3 on a branch still decodes with branch asserted.

## Structure
- Package cu_pkg holds:
  - opcode constants;
  - ALU control, immsrc and resultsrc encodings;
  - a packed control-bundle struct used by all three stage registers.
- Sub-module cu_decode: combinational main decoder plus ALU decoder, producing the bundle and illegalD. cu_pipe holds the stage registers, the branch-condition logic and the trap flag.

## Test plan
- Reset: hold rst_n=0 -> all E/M/W outputs and trapW are 0. Release rst_n with opD=0 -> outputs stay 0.
- R-type sub (opD=0110011, funct3D=000, funct7_5D=1) at cycle N:
  - N+1: ALUctrlE=0001.
  - N+2: regwrM=1.
  - N+3: regwrW=1, resultsrcW=00.
- srai (opD=0010011, funct3D=101, funct7_5D=1) -> ALUctrlE=1001, ALUsrcE=1, immsrcD=000.
- bne (funct3=001) in Execute:
  - zeroE=0 -> pcsrcE=1, and the next Execute register is a bubble even with a valid R-type in Decode.
  - zeroE=1 -> pcsrcE=0.
- lw in Decode with flushE=1 -> next cycle all Execute control is 0, regwrM=0 one cycle later. jal -> pcsrcE=1, resultsrcW=10 at N+3.
- opD=1111111 -> illegalD=1.
  - CU_ILLEGAL_TRAP_EN defined: trapW=1 at N+3 and stays 1 across later valid instructions.
  - CU_ILLEGAL_TRAP_EN undefined: trapW=0.

Source files
------------

// File: rtl/cu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cu_pkg : opcodes, control encodings and the stage control bundle   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package cu_pkg;

  localparam logic [6:0] c_OP_R      = 7'b0110011;
  localparam logic [6:0] c_OP_IALU   = 7'b0010011;
  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OP_JAL    = 7'b1101111;
  localparam logic [6:0] c_OP_JALR   = 7'b1100111;
  localparam logic [6:0] c_OP_LUI    = 7'b0110111;
  localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] c_ALU_ADD   = 4'b0000;
  localparam logic [3:0] c_ALU_SUB   = 4'b0001;
  localparam logic [3:0] c_ALU_AND   = 4'b0010;
  localparam logic [3:0] c_ALU_OR    = 4'b0011;
  localparam logic [3:0] c_ALU_XOR   = 4'b0100;
  localparam logic [3:0] c_ALU_SLT   = 4'b0101;
  localparam logic [3:0] c_ALU_SLTU  = 4'b0110;
  localparam logic [3:0] c_ALU_SLL   = 4'b0111;
  localparam logic [3:0] c_ALU_SRL   = 4'b1000;
  localparam logic [3:0] c_ALU_SRA   = 4'b1001;
  localparam logic [3:0] c_ALU_PASSB = 4'b1010;

  localparam logic [2:0] c_IMM_I = 3'b000;
  localparam logic [2:0] c_IMM_S = 3'b001;
  localparam logic [2:0] c_IMM_B = 3'b010;
  localparam logic [2:0] c_IMM_J = 3'b011;
  localparam logic [2:0] c_IMM_U = 3'b100;

  localparam logic [1:0] c_RES_ALU = 2'b00;
  localparam logic [1:0] c_RES_MEM = 2'b01;
  localparam logic [1:0] c_RES_PC4 = 2'b10;

  typedef struct packed {
    logic       regwr;
    logic [1:0] resultsrc;
    logic       memwr;
    logic       jump;
    logic       jalr;
    logic       branch;
    logic [3:0] aluctrl;
    logic       alusrc;
    logic       alusrcA;
    logic [2:0] funct3;   // kept only for branches, resolved in Execute
    logic       trap;
  } ctrlBundle_t;

endpackage
`default_nettype wire

// File: rtl/cu_decode.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cu_decode : combinational main decoder and ALU decoder             |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module cu_decode
  import cu_pkg::*;
(
  input  logic [6:0]  i_opD,
  input  logic [2:0]  i_funct3D,
  input  logic        i_funct7_5D,
  output ctrlBundle_t o_ctrl,
  output logic [2:0]  o_immsrc,
  output logic        o_illegal
);

  logic [1:0] w_aluOp;

  always_comb begin
    o_ctrl    = '0;
    o_immsrc  = c_IMM_I;
    o_illegal = 1'b0;
    w_aluOp   = 2'b00;
    case (i_opD)
      c_OP_R: begin
        o_ctrl.regwr = 1'b1;
        w_aluOp      = 2'b10;
      end
      c_OP_IALU: begin
        o_ctrl.regwr  = 1'b1;
        o_ctrl.alusrc = 1'b1;
        w_aluOp       = 2'b10;
      end
      c_OP_LOAD: begin
        o_ctrl.regwr     = 1'b1;
        o_ctrl.alusrc    = 1'b1;
        o_ctrl.resultsrc = c_RES_MEM;
        o_illegal        = (i_funct3D == 3'b011) || (i_funct3D[2:1] == 2'b11);
      end
      c_OP_STORE: begin
        o_ctrl.memwr  = 1'b1;
        o_ctrl.alusrc = 1'b1;
        o_immsrc      = c_IMM_S;
        o_illegal     = i_funct3D[2] || (i_funct3D[1:0] == 2'b11);
      end
      c_OP_BRANCH: begin
        o_ctrl.branch = 1'b1;
        o_ctrl.funct3 = i_funct3D;
        o_immsrc      = c_IMM_B;
        w_aluOp       = 2'b01;
        o_illegal     = (i_funct3D[2:1] == 2'b01);
      end
      c_OP_JAL: begin
        o_ctrl.regwr     = 1'b1;
        o_ctrl.jump      = 1'b1;
        o_ctrl.resultsrc = c_RES_PC4;
        o_immsrc         = c_IMM_J;
      end
      c_OP_JALR: begin
        o_ctrl.regwr     = 1'b1;
        o_ctrl.jump      = 1'b1;
        o_ctrl.jalr      = 1'b1;
        o_ctrl.alusrc    = 1'b1;
        o_ctrl.resultsrc = c_RES_PC4;
        o_illegal        = (i_funct3D != 3'b000);
      end
      c_OP_LUI: begin
        o_ctrl.regwr  = 1'b1;
        o_ctrl.alusrc = 1'b1;
        o_immsrc      = c_IMM_U;
        w_aluOp       = 2'b11;
      end
      c_OP_AUIPC: begin
        o_ctrl.regwr   = 1'b1;
        o_ctrl.alusrc  = 1'b1;
        o_ctrl.alusrcA = 1'b1;
        o_immsrc       = c_IMM_U;
      end
      default: o_illegal = 1'b1;
    endcase

    case (w_aluOp)
      2'b00: o_ctrl.aluctrl = c_ALU_ADD;
      2'b01: o_ctrl.aluctrl = c_ALU_SUB;
      2'b11: o_ctrl.aluctrl = c_ALU_PASSB;
      default: begin
        case (i_funct3D)
          // bit 30 is an immediate bit for addi, so only R-type may subtract
          3'b000:  o_ctrl.aluctrl = (i_opD[5] && i_funct7_5D) ? c_ALU_SUB : c_ALU_ADD;
          3'b001:  o_ctrl.aluctrl = c_ALU_SLL;
          3'b010:  o_ctrl.aluctrl = c_ALU_SLT;
          3'b011:  o_ctrl.aluctrl = c_ALU_SLTU;
          3'b100:  o_ctrl.aluctrl = c_ALU_XOR;
          3'b101:  o_ctrl.aluctrl = i_funct7_5D ? c_ALU_SRA : c_ALU_SRL;
          3'b110:  o_ctrl.aluctrl = c_ALU_OR;
          default: o_ctrl.aluctrl = c_ALU_AND;
        endcase
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/cu_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cu_pipe : pipelined RV32I control unit (Decode -> E/M/W registers) |
// | Option macro: CU_ILLEGAL_TRAP_EN (illegal-instruction trap path)   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module cu_pipe
  import cu_pkg::*;
#(
  parameter int ALUCTRL_W = 4,
  parameter int IMMSRC_W  = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           opD,
  input  logic [2:0]           funct3D,
  input  logic                 funct7_5D,
  input  logic                 flushE,
  input  logic                 zeroE,
  input  logic                 ltE,
  input  logic                 ltuE,
  output logic [IMMSRC_W-1:0]  immsrcD,
  output logic                 illegalD,
  output logic                 ALUsrcAE,
  output logic                 ALUsrcE,
  output logic [ALUCTRL_W-1:0] ALUctrlE,
  output logic                 jumpE,
  output logic                 jalrE,
  output logic                 branchE,
  output logic                 pcsrcE,
  output logic                 memwrM,
  output logic                 regwrM,
  output logic                 regwrW,
  output logic [1:0]           resultsrcM,
  output logic [1:0]           resultsrcW,
  output logic                 trapW
);

  ctrlBundle_t w_ctrlD;
  ctrlBundle_t w_ctrlENext;
  ctrlBundle_t r_ctrlE;
  ctrlBundle_t r_ctrlM;
  ctrlBundle_t r_ctrlW;
  logic [2:0]  w_immsrcD;
  logic        w_illegalD;
  logic        w_condE;
  logic        w_pcsrcE;
  logic        w_unusedStageBits;

  cu_decode u_decode (
    .i_opD       (opD),
    .i_funct3D   (funct3D),
    .i_funct7_5D (funct7_5D),
    .o_ctrl      (w_ctrlD),
    .o_immsrc    (w_immsrcD),
    .o_illegal   (w_illegalD)
  );

  always_comb begin
    case (r_ctrlE.funct3)
      3'b000:  w_condE = zeroE;
      3'b001:  w_condE = !zeroE;
      3'b100:  w_condE = ltE;
      3'b101:  w_condE = !ltE;
      3'b110:  w_condE = ltuE;
      3'b111:  w_condE = !ltuE;
      default: w_condE = 1'b0;
    endcase
  end

  assign w_pcsrcE = r_ctrlE.jump | (r_ctrlE.branch & w_condE);

`ifdef CU_ILLEGAL_TRAP_EN
  logic r_trapW;

  // an illegal instruction becomes a bubble that carries only its trap bit
  always_comb begin
    w_ctrlENext = w_ctrlD;
    if (w_illegalD) begin
      w_ctrlENext      = '0;
      w_ctrlENext.trap = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_trapW <= 1'b0;
    end else begin
      r_trapW <= r_trapW | r_ctrlM.trap;
    end
  end

  assign trapW = r_trapW;
`else
  assign w_ctrlENext = w_ctrlD;
  assign trapW       = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrlE <= '0;
      r_ctrlM <= '0;
      r_ctrlW <= '0;
    end else begin
      r_ctrlE <= (flushE || w_pcsrcE) ? '0 : w_ctrlENext;
      r_ctrlM <= r_ctrlE;
      r_ctrlW <= r_ctrlM;
    end
  end

  // later stages only consume a subset of the shared bundle
  assign w_unusedStageBits = ^{r_ctrlM, r_ctrlW};

  assign immsrcD    = IMMSRC_W'(w_immsrcD);
  assign illegalD   = w_illegalD;
  assign ALUsrcAE   = r_ctrlE.alusrcA;
  assign ALUsrcE    = r_ctrlE.alusrc;
  assign ALUctrlE   = ALUCTRL_W'(r_ctrlE.aluctrl);
  assign jumpE      = r_ctrlE.jump;
  assign jalrE      = r_ctrlE.jalr;
  assign branchE    = r_ctrlE.branch;
  assign pcsrcE     = w_pcsrcE;
  assign memwrM     = r_ctrlM.memwr;
  assign regwrM     = r_ctrlM.regwr;
  assign resultsrcM = r_ctrlM.resultsrc;
  assign regwrW     = r_ctrlW.regwr;
  assign resultsrcW = r_ctrlW.resultsrc;

endmodule
`default_nettype wire

// File: tb/tb_cu_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_cu_pipe : directed self-checking bench for cu_pipe              |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_cu_pipe;

  localparam logic [6:0] c_OP_R      = 7'b0110011;
  localparam logic [6:0] c_OP_IALU   = 7'b0010011;
  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OP_JAL    = 7'b1101111;
  localparam logic [6:0] c_OP_JALR   = 7'b1100111;
  localparam logic [6:0] c_OP_LUI    = 7'b0110111;
  localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] c_OP_IDLE   = 7'b0000000;
  localparam logic [6:0] c_OP_BAD    = 7'b1111111;
`ifdef CU_ILLEGAL_TRAP_EN
  localparam logic c_EXP_TRAP = 1'b1;
`else
  localparam logic c_EXP_TRAP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opD = '0;
  logic [2:0] funct3D = '0;
  logic       funct7_5D = 1'b0;
  logic       flushE = 1'b0;
  logic       zeroE = 1'b0;
  logic       ltE = 1'b0;
  logic       ltuE = 1'b0;
  logic [2:0] immsrcD;
  logic       illegalD, ALUsrcAE, ALUsrcE, jumpE, jalrE, branchE, pcsrcE;
  logic [3:0] ALUctrlE;
  logic       memwrM, regwrM, regwrW, trapW;
  logic [1:0] resultsrcM, resultsrcW;

  int tests = 0;
  int failed = 0;

  // {ALUsrcAE, ALUsrcE, ALUctrlE, jumpE, jalrE, branchE, pcsrcE}
  wire [9:0] eVec  = {ALUsrcAE, ALUsrcE, ALUctrlE, jumpE, jalrE, branchE, pcsrcE};
  wire [7:0] mwVec = {memwrM, regwrM, resultsrcM, regwrW, resultsrcW, trapW};

  cu_pipe #(.ALUCTRL_W(4), .IMMSRC_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .opD(opD), .funct3D(funct3D), .funct7_5D(funct7_5D),
    .flushE(flushE), .zeroE(zeroE), .ltE(ltE), .ltuE(ltuE),
    .immsrcD(immsrcD), .illegalD(illegalD), .ALUsrcAE(ALUsrcAE), .ALUsrcE(ALUsrcE),
    .ALUctrlE(ALUctrlE), .jumpE(jumpE), .jalrE(jalrE), .branchE(branchE), .pcsrcE(pcsrcE),
    .memwrM(memwrM), .regwrM(regwrM), .regwrW(regwrW),
    .resultsrcM(resultsrcM), .resultsrcW(resultsrcW), .trapW(trapW)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic setD(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    opD = op;
    funct3D = f3;
    funct7_5D = f7;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    setD(c_OP_R, 3'b000, 1'b1);
    tick; tick;
    tests++; if (eVec !== 10'd0) begin failed++; $display("FAIL reset_e: got %b expected %b", eVec, 10'd0); end
    tests++; if (mwVec !== 8'd0) begin failed++; $display("FAIL reset_mw: got %b expected %b", mwVec, 8'd0); end
    setD(c_OP_IDLE, 3'b000, 1'b0);
    rst_n = 1'b1;
    tick; tick;
    tests++; if (eVec !== 10'd0) begin failed++; $display("FAIL release_e: got %b expected %b", eVec, 10'd0); end
    tests++; if (mwVec !== 8'd0) begin failed++; $display("FAIL release_mw: got %b expected %b", mwVec, 8'd0); end
  endtask

  task automatic test_rtype_sub;
    setD(c_OP_R, 3'b000, 1'b1);
    tick;
    setD(c_OP_IDLE, 3'b000, 1'b0);
    tests++; if (eVec !== 10'b00_0001_0000) begin failed++; $display("FAIL sub_e: got %b expected %b", eVec, 10'b00_0001_0000); end
    tick;
    tests++; if ({memwrM, regwrM, resultsrcM} !== 4'b0100) begin failed++; $display("FAIL sub_m: got %b expected 0100", {memwrM, regwrM, resultsrcM}); end
    tick;
    tests++; if ({regwrW, resultsrcW} !== 3'b100) begin failed++; $display("FAIL sub_w: got %b expected 100", {regwrW, resultsrcW}); end
    // addi with bit 30 set must still add
    setD(c_OP_IALU, 3'b000, 1'b1);
    tick;
    tests++; if ({ALUsrcE, ALUctrlE} !== 5'b1_0000) begin failed++; $display("FAIL addi_b30: got %b expected 10000", {ALUsrcE, ALUctrlE}); end
    setD(c_OP_IDLE, 3'b000, 1'b0);
    tick;
  endtask

  task automatic test_srai;
    setD(c_OP_IALU, 3'b101, 1'b1);
    #1;
    tests++; if ({immsrcD, illegalD} !== 4'b0000) begin failed++; $display("FAIL srai_dec: got %b expected 0000", {immsrcD, illegalD}); end
    tick;
    tests++; if ({ALUsrcE, ALUctrlE} !== 5'b1_1001) begin failed++; $display("FAIL srai_e: got %b expected 11001", {ALUsrcE, ALUctrlE}); end
    setD(c_OP_IALU, 3'b101, 1'b0);
    tick;
    tests++; if ({ALUsrcE, ALUctrlE} !== 5'b1_1000) begin failed++; $display("FAIL srli_e: got %b expected 11000", {ALUsrcE, ALUctrlE}); end
    setD(c_OP_R, 3'b101, 1'b1);
    tick;
    tests++; if ({ALUsrcE, ALUctrlE} !== 5'b0_1001) begin failed++; $display("FAIL sra_e: got %b expected 01001", {ALUsrcE, ALUctrlE}); end
    setD(c_OP_IDLE, 3'b000, 1'b0);
    tick;
  endtask

  task automatic test_alu_table;
    logic [3:0] expTab [8];
    expTab = '{4'b0000, 4'b0111, 4'b0101, 4'b0110, 4'b0100, 4'b1000, 4'b0011, 4'b0010};
    for (int f = 0; f < 8; f++) begin
      setD(c_OP_R, 3'(f), 1'b0);
      tick;
      tests++; if (ALUctrlE !== expTab[f]) begin failed++; $display("FAIL alu_f3_%0d: got %b expected %b", f, ALUctrlE, expTab[f]); end
    end
    setD(c_OP_IDLE, 3'b000, 1'b0);
    tick;
  endtask

  task automatic test_branch;
    logic [6:0] condTab [8];
    // {funct3, zeroE, ltE, ltuE, expected pcsrcE}
    condTab = '{7'b000_100_1, 7'b000_011_0, 7'b100_010_1, 7'b101_010_0,
                7'b110_001_1, 7'b111_001_0, 7'b101_101_1, 7'b001_111_0};
    setD(c_OP_BRANCH, 3'b001, 1'b0);
    #1;
    tests++; if ({immsrcD, illegalD} !== 4'b0100) begin failed++; $display("FAIL bne_dec: got %b expected 0100", {immsrcD, illegalD}); end
    tick;
    setD(c_OP_R, 3'b000, 1'b0);
    zeroE = 1'b0;
    #1;
    tests++; if (eVec !== 10'b00_0001_0011) begin failed++; $display("FAIL bne_taken: got %b expected %b", eVec, 10'b00_0001_0011); end
    tick;
    tests++; if (eVec !== 10'd0) begin failed++; $display("FAIL bne_bubble: got %b expected %b", eVec, 10'd0); end
    setD(c_OP_IDLE, 3'b000, 1'b0);
    tick;
    tests++; if (regwrM !== 1'b0) begin failed++; $display("FAIL bne_dropped: got %b expected 0", regwrM); end
    setD(c_OP_BRANCH, 3'b001, 1'b0);
    tick;
    setD(c_OP_R, 3'b000, 1'b0);
    zeroE = 1'b1;
    #1;
    tests++; if ({branchE, pcsrcE} !== 2'b10) begin failed++; $display("FAIL bne_not_taken: got %b expected 10", {branchE, pcsrcE}); end
    tick;
    zeroE = 1'b0;
    setD(c_OP_IDLE, 3'b000, 1'b0);
    tick;
    tests++; if (regwrM !== 1'b1) begin failed++; $display("FAIL bne_fallthrough: got %b expected 1", regwrM); end
    for (int k = 0; k < 8; k++) begin
      setD(c_OP_BRANCH, condTab[k][6:4], 1'b0);
      tick;
      setD(c_OP_IDLE, 3'b000, 1'b0);
      {zeroE, ltE, ltuE} = condTab[k][3:1];
      #1;
      tests++; if (pcsrcE !== condTab[k][0]) begin failed++; $display("FAIL br_cond_%0d: got %b expected %b", k, pcsrcE, condTab[k][0]); end
      tick;
      {zeroE, ltE, ltuE} = 3'b000;
    end
  endtask

  task automatic test_flush;
    setD(c_OP_LOAD, 3'b010, 1'b0);
    flushE = 1'b1;
    tick;
    flushE = 1'b0;
    setD(c_OP_IDLE, 3'b000, 1'b0);
    tests++; if (eVec !== 10'd0) begin failed++; $display("FAIL lw_flush_e: got %b expected %b", eVec, 10'd0); end
    tick;
    tests++; if ({regwrM, resultsrcM} !== 3'b000) begin failed++; $display("FAIL lw_flush_m: got %b expected 000", {regwrM, resultsrcM}); end
    setD(c_OP_LOAD, 3'b010, 1'b0);
    tick;
    setD(c_OP_IDLE, 3'b000, 1'b0);
    tests++; if ({ALUsrcE, ALUctrlE} !== 5'b1_0000) begin failed++; $display("FAIL lw_e: got %b expected 10000", {ALUsrcE, ALUctrlE}); end
    tick;
    tests++; if ({memwrM, regwrM, resultsrcM} !== 4'b0101) begin failed++; $display("FAIL lw_m: got %b expected 0101", {memwrM, regwrM, resultsrcM}); end
    setD(c_OP_STORE, 3'b010, 1'b0);
    #1;
    tests++; if (immsrcD !== 3'b001) begin failed++; $display("FAIL sw_imm: got %b expected 001", immsrcD); end
    tick;
    setD(c_OP_IDLE, 3'b000, 1'b0);
    tick;
    tests++; if ({memwrM, regwrM, resultsrcM} !== 4'b1000) begin failed++; $display("FAIL sw_m: got %b expected 1000", {memwrM, regwrM, resultsrcM}); end
    // flushE together with a taken jump: exactly one bubble
    setD(c_OP_JAL, 3'b000, 1'b0);
    tick;
    setD(c_OP_R, 3'b000, 1'b1);
    flushE = 1'b1;
    #1;
    tests++; if (pcsrcE !== 1'b1) begin failed++; $display("FAIL flush_jal_pc: got %b expected 1", pcsrcE); end
    tick;
    flushE = 1'b0;
    tests++; if (eVec !== 10'd0) begin failed++; $display("FAIL flush_jal_bubble: got %b expected %b", eVec, 10'd0); end
    tick;
    tests++; if (ALUctrlE !== 4'b0001) begin failed++; $display("FAIL flush_jal_next: got %b expected 0001", ALUctrlE); end
    setD(c_OP_IDLE, 3'b000, 1'b0);
    tick;
  endtask

  task automatic test_jumps;
    setD(c_OP_JAL, 3'b000, 1'b0);
    #1;
    tests++; if (immsrcD !== 3'b011) begin failed++; $display("FAIL jal_imm: got %b expected 011", immsrcD); end
    tick;
    setD(c_OP_IDLE, 3'b000, 1'b0);
    tests++; if (eVec !== 10'b00_0000_1001) begin failed++; $display("FAIL jal_e: got %b expected %b", eVec, 10'b00_0000_1001); end
    tick;
    tests++; if ({regwrM, resultsrcM} !== 3'b110) begin failed++; $display("FAIL jal_m: got %b expected 110", {regwrM, resultsrcM}); end
    tick;
    tests++; if ({regwrW, resultsrcW} !== 3'b110) begin failed++; $display("FAIL jal_w: got %b expected 110", {regwrW, resultsrcW}); end
    setD(c_OP_JALR, 3'b000, 1'b0);
    tick;
    setD(c_OP_IDLE, 3'b000, 1'b0);
    tests++; if (eVec !== 10'b01_0000_1101) begin failed++; $display("FAIL jalr_e: got %b expected %b", eVec, 10'b01_0000_1101); end
    tick;
    setD(c_OP_LUI, 3'b101, 1'b1);
    #1;
    tests++; if (immsrcD !== 3'b100) begin failed++; $display("FAIL lui_imm: got %b expected 100", immsrcD); end
    tick;
    tests++; if ({ALUsrcAE, ALUsrcE, ALUctrlE} !== 6'b01_1010) begin failed++; $display("FAIL lui_e: got %b expected 011010", {ALUsrcAE, ALUsrcE, ALUctrlE}); end
    setD(c_OP_AUIPC, 3'b111, 1'b1);
    tick;
    tests++; if ({ALUsrcAE, ALUsrcE, ALUctrlE} !== 6'b11_0000) begin failed++; $display("FAIL auipc_e: got %b expected 110000", {ALUsrcAE, ALUsrcE, ALUctrlE}); end
    setD(c_OP_IDLE, 3'b000, 1'b0);
    tick;
  endtask

  task automatic test_midstream_reset;
    setD(c_OP_R, 3'b000, 1'b1);
    tick; tick;
    setD(c_OP_IDLE, 3'b000, 1'b0);
    tests++; if (regwrM !== 1'b1) begin failed++; $display("FAIL pre_reset_m: got %b expected 1", regwrM); end
    #2;
    rst_n = 1'b0;
    #1;
    tests++; if (eVec !== 10'd0) begin failed++; $display("FAIL async_reset_e: got %b expected %b", eVec, 10'd0); end
    tests++; if (mwVec !== 8'd0) begin failed++; $display("FAIL async_reset_mw: got %b expected %b", mwVec, 8'd0); end
    tick;
    rst_n = 1'b1;
  endtask

  task automatic test_illegal;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    setD(c_OP_BAD, 3'b000, 1'b0);
    #1;
    tests++; if (illegalD !== 1'b1) begin failed++; $display("FAIL ill_op: got %b expected 1", illegalD); end
    tick;
    setD(c_OP_IALU, 3'b000, 1'b0);
    #1;
    tests++; if (illegalD !== 1'b0) begin failed++; $display("FAIL addi_legal: got %b expected 0", illegalD); end
    tick;
    tests++; if (trapW !== 1'b0) begin failed++; $display("FAIL trap_early: got %b expected 0", trapW); end
    tick;
    tests++; if (trapW !== c_EXP_TRAP) begin failed++; $display("FAIL trap_n3: got %b expected %b", trapW, c_EXP_TRAP); end
    tick; tick;
    tests++; if (trapW !== c_EXP_TRAP) begin failed++; $display("FAIL trap_sticky: got %b expected %b", trapW, c_EXP_TRAP); end
    setD(c_OP_LOAD, 3'b110, 1'b0);
    #1;
    tests++; if (illegalD !== 1'b1) begin failed++; $display("FAIL ill_load: got %b expected 1", illegalD); end
    setD(c_OP_JALR, 3'b001, 1'b0);
    #1;
    tests++; if (illegalD !== 1'b1) begin failed++; $display("FAIL ill_jalr: got %b expected 1", illegalD); end
    setD(c_OP_BRANCH, 3'b010, 1'b0);
    #1;
    tests++; if (illegalD !== 1'b1) begin failed++; $display("FAIL ill_branch: got %b expected 1", illegalD); end
    tick;
    setD(c_OP_IDLE, 3'b000, 1'b0);
    tests++; if (branchE !== ~c_EXP_TRAP) begin failed++; $display("FAIL ill_branch_e: got %b expected %b", branchE, ~c_EXP_TRAP); end
    tick;
  endtask

  initial begin
    test_reset;
    test_rtype_sub;
    test_srai;
    test_alu_table;
    test_branch;
    test_flush;
    test_jumps;
    test_midstream_reset;
    test_illegal;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire
